// File: rtl/mem_req_arb.sv
// Round-robin arbiter funnelling NUM_REQ memory-request ports into one registered
// request channel with a valid/ready handshake on both sides.
package dcp_pkg;
    typedef logic [4:0]  req_type_t;
    typedef logic [7:0]  mshrid_t;
    typedef logic [39:0] paddr_t;
    typedef logic [2:0]  size_t;
    typedef logic [15:0] homeid_t;
    typedef logic [7:0]  write_mask_t;
    typedef logic [63:0] data_t;
endpackage

module mem_req_arb
    import dcp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_en,
    input  logic [NUM_REQ-1:0]   in_valid,
    output logic [NUM_REQ-1:0]   in_ready,
    input  req_type_t            in_req_type   [NUM_REQ],
    input  mshrid_t              in_mshrid     [NUM_REQ],
    input  paddr_t               in_address    [NUM_REQ],
    input  size_t                in_size       [NUM_REQ],
    input  homeid_t              in_homeid     [NUM_REQ],
    input  write_mask_t          in_write_mask [NUM_REQ],
    input  data_t                in_data_0     [NUM_REQ],
    input  data_t                in_data_1     [NUM_REQ],
    output logic                 out_valid,
    input  logic                 out_ready,
    output req_type_t            out_req_type,
    output mshrid_t              out_mshrid,
    output paddr_t               out_address,
    output size_t                out_size,
    output homeid_t              out_homeid,
    output write_mask_t          out_write_mask,
    output data_t                out_data_0,
    output data_t                out_data_1,
    output logic [IDW-1:0]       out_src_id
);

    typedef struct packed {
        req_type_t   req_type;
        mshrid_t     mshrid;
        paddr_t      address;
        size_t       size;
        homeid_t     homeid;
        write_mask_t write_mask;
        data_t       data_0;
        data_t       data_1;
    } payload_t;

    logic               out_valid_q, out_valid_d;
    logic [IDW-1:0]     src_id_q, src_id_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    payload_t           payload_q, payload_d;

    logic [NUM_REQ-1:0] eligible;
    logic               reg_free;
    logic               any_eligible;
    logic               grant;
    logic [IDW-1:0]     grant_idx;

    always_comb begin
        reg_free     = !out_valid_q || out_ready;
        eligible     = in_valid & req_en;
        any_eligible = 1'b0;
        grant_idx    = '0;
        // Scan upward from rr_ptr; the candidate index wraps at NUM_REQ,
        // which need not be a power of two.
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [IDW:0] cand;
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!any_eligible && eligible[cand[IDW-1:0]]) begin
                any_eligible = 1'b1;
                grant_idx    = cand[IDW-1:0];
            end
        end
        grant = reg_free && any_eligible && !rst;
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign in_ready[gi] = grant && (grant_idx == IDW'(gi));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        src_id_d    = src_id_q;
        rr_ptr_d    = rr_ptr_q;
        payload_d   = payload_q;
        if (reg_free) begin
            out_valid_d = grant;
        end
        if (grant) begin
            src_id_d  = grant_idx;
            rr_ptr_d  = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            payload_d = '{
                req_type:   in_req_type[grant_idx],
                mshrid:     in_mshrid[grant_idx],
                address:    in_address[grant_idx],
                size:       in_size[grant_idx],
                homeid:     in_homeid[grant_idx],
                write_mask: in_write_mask[grant_idx],
                data_0:     in_data_0[grant_idx],
                data_1:     in_data_1[grant_idx]
            };
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            src_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            src_id_q    <= src_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Payload is qualified by out_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        payload_q <= payload_d;
    end

    assign out_valid      = out_valid_q;
    assign out_src_id     = src_id_q;
    assign out_req_type   = payload_q.req_type;
    assign out_mshrid     = payload_q.mshrid;
    assign out_address    = payload_q.address;
    assign out_size       = payload_q.size;
    assign out_homeid     = payload_q.homeid;
    assign out_write_mask = payload_q.write_mask;
    assign out_data_0     = payload_q.data_0;
    assign out_data_1     = payload_q.data_1;

endmodule

// File: tb/tb_mem_req_arb.sv
// Directed and random checks of mem_req_arb: expected requests are queued at the
// input handshake and compared when they appear on the output channel.
module tb_mem_req_arb;
    import dcp_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0] req_en, in_valid, in_ready;
    logic         out_valid, out_ready;
    logic [1:0]   out_src_id;
    req_type_t    in_req_type [N];
    mshrid_t      in_mshrid [N];
    paddr_t       in_address [N];
    size_t        in_size [N];
    homeid_t      in_homeid [N];
    write_mask_t  in_write_mask [N];
    data_t        in_data_0 [N];
    data_t        in_data_1 [N];
    req_type_t    out_req_type;
    mshrid_t      out_mshrid;
    paddr_t       out_address;
    size_t        out_size;
    homeid_t      out_homeid;
    write_mask_t  out_write_mask;
    data_t        out_data_0, out_data_1;

    mem_req_arb #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req_en(req_en), .in_valid(in_valid), .in_ready(in_ready),
        .in_req_type(in_req_type), .in_mshrid(in_mshrid), .in_address(in_address),
        .in_size(in_size), .in_homeid(in_homeid), .in_write_mask(in_write_mask),
        .in_data_0(in_data_0), .in_data_1(in_data_1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_req_type(out_req_type), .out_mshrid(out_mshrid), .out_address(out_address),
        .out_size(out_size), .out_homeid(out_homeid), .out_write_mask(out_write_mask),
        .out_data_0(out_data_0), .out_data_1(out_data_1), .out_src_id(out_src_id)
    );

    typedef struct packed {
        logic [1:0]  src;
        req_type_t   rt;
        mshrid_t     ms;
        paddr_t      addr;
        size_t       sz;
        homeid_t     hid;
        write_mask_t wm;
        data_t       d0;
        data_t       d1;
    } pkt_t;

    pkt_t dut_pkt;
    assign dut_pkt = pkt_t'({out_src_id, out_req_type, out_mshrid, out_address, out_size,
                             out_homeid, out_write_mask, out_data_0, out_data_1});

    pkt_t         q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           rr_m = 0;
    logic         exp_valid = 1'b0;
    int           last_grant = -1;
    logic [N-1:0] last_rdy;
    int           wait_cnt [N];
    bit           rand_mode = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_payload(input int i);
        in_req_type[i]   = req_type_t'($urandom);
        in_mshrid[i]     = mshrid_t'($urandom);
        in_address[i]    = paddr_t'({$urandom, $urandom});
        in_size[i]       = size_t'($urandom);
        in_homeid[i]     = homeid_t'($urandom);
        in_write_mask[i] = write_mask_t'($urandom);
        in_data_0[i]     = {$urandom, $urandom};
        in_data_1[i]     = {$urandom, $urandom};
    endtask

    function automatic pkt_t mk_pkt(input int w);
        return pkt_t'({2'(w), in_req_type[w], in_mshrid[w], in_address[w], in_size[w],
                       in_homeid[w], in_write_mask[w], in_data_0[w], in_data_1[w]});
    endfunction

    task automatic model_reset();
        rr_m = 0;
        exp_valid = 1'b0;
        q.delete();
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    // One clock: check the combinational grant at the falling edge, score the
    // output register, predict the next state, then advance past the rising edge.
    task automatic step();
        logic [N-1:0] elig, exp_rdy;
        logic free;
        int w;
        @(negedge clk);
        elig = in_valid & req_en;
        free = !exp_valid || out_ready;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr_m + k) % N;
            if (w < 0 && elig[idx]) w = idx;
        end
        exp_rdy = (free && w >= 0) ? (N'(1) << w) : '0;
        last_rdy = in_ready;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            chk("sb_underflow", q.size() == 0, 0);
            if (q.size() != 0) begin
                chk("payload", dut_pkt, q[0]);
                if (out_ready) void'(q.pop_front());
            end
        end
        last_grant = -1;
        if (free && w >= 0) begin
            q.push_back(mk_pkt(w));
            $display("grant req=%0d addr=%h rr_next=%0d", w, in_address[w], (w + 1) % N);
            for (int i = 0; i < N; i++) begin
                if (i == w || !elig[i]) begin
                    wait_cnt[i] = 0;
                end else begin
                    wait_cnt[i]++;
                    chk("fairness", wait_cnt[i] <= N - 1, 1);
                end
            end
            rr_m = (w + 1) % N;
            last_grant = w;
        end
        if (free) exp_valid = (w >= 0);
        @(posedge clk);
        #1;
        if (last_grant >= 0) begin
            new_payload(last_grant);
            if (rand_mode) in_valid[last_grant] = 1'($urandom % 2);
        end
    endtask

    int   rr_exp [5] = '{0, 1, 2, 3, 0};
    pkt_t held;
    int   prev;

    initial begin
        req_en    = '1;
        in_valid  = '1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) new_payload(i);
        model_reset();

        // Reset holds everything idle even with all requesters eligible.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_src", out_src_id, 0);
        chk("reset_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = '0;

        // Single request from requester 2.
        in_valid = 4'b0100;
        in_address[2] = 40'h1000;
        step();
        chk("single_rdy", last_rdy, 4'b0100);
        chk("single_valid", out_valid, 1);
        chk("single_addr", out_address, 40'h1000);
        chk("single_src", out_src_id, 2);

        // Reset mid-transfer with rr_ptr at 3; first grant afterwards is requester 0.
        in_valid = '1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_src", out_src_id, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        for (int s = 0; s < 5; s++) begin
            step();
            chk("rr_order", last_grant, rr_exp[s]);
        end

        // Backpressure: output must hold and no grant may be issued.
        out_ready = 1'b0;
        held = dut_pkt;
        for (int s = 0; s < 5; s++) begin
            step();
            chk("bp_ready", last_rdy, 0);
            chk("bp_hold", dut_pkt, held);
        end
        out_ready = 1'b1;
        step();
        chk("bp_resume", last_grant >= 0, 1);

        // Enable mask: only odd requesters, alternating.
        req_en = 4'b1010;
        prev = -1;
        for (int s = 0; s < 6; s++) begin
            step();
            chk("mask_granted", last_grant >= 0, 1);
            chk("mask_odd", last_grant % 2, 1);
            if (prev >= 0) chk("mask_alt", last_grant, (prev == 1) ? 3 : 1);
            prev = last_grant;
        end

        // Random traffic with random backpressure.
        req_en = '1;
        rand_mode = 1'b1;
        for (int c = 0; c < 200; c++) begin
            out_ready = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] && ($urandom % 2 == 1)) begin
                    new_payload(i);
                    in_valid[i] = 1'b1;
                end
            end
            step();
        end

        // Drain.
        in_valid = '0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("sb_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_req_arb.md
MEM_REQ_ARB -- requirements
Module: mem_req_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester ports sharing one memory request channel (2..8).
REQ-002 Parameter IDW, default $clog2(NUM_REQ), width of the source-id tag.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_en  input  NUM_REQ  per-requester arbitration enable; bit i low excludes requester i from arbitration.
REQ-006 in_valid  input  NUM_REQ  requester i presents a request.
REQ-007 in_ready  output  NUM_REQ  request of requester i accepted this cycle.
REQ-008 in_req_type/in_mshrid/in_address/in_size/in_homeid/in_write_mask/in_data_0/in_data_1  input  NUM_REQ x dcp_pkg type width (req_type_t, mshrid_t, paddr_t, size_t, homeid_t, write_mask_t, data_t, data_t)  per-requester payload.
REQ-009 out_valid  output  1  registered request on the shared channel.
REQ-010 out_ready  input  1  downstream accepts the output request.
REQ-011 out_req_type/out_mshrid/out_address/out_size/out_homeid/out_write_mask/out_data_0/out_data_1  output  dcp_pkg type widths  registered payload.
REQ-012 out_src_id  output  IDW  index of the requester whose payload is in the output register.

Function
REQ-013 The output register is "free" when out_valid=0 or out_ready=1 in the current cycle.
REQ-014 Eligible requesters: in_valid[i] & req_en[i].
REQ-015 Winner: first eligible index at or after rr_ptr, searching upward modulo NUM_REQ.
REQ-016 in_ready[i]=1 only when the register is free, at least one requester is eligible, and i is the winner; at most one in_ready bit is high per cycle.
REQ-017 in_ready[i] is never high while in_valid[i]=0 or req_en[i]=0.
REQ-018 On a grant, the next edge loads the winner's payload into the output register, sets out_src_id to the winner, and sets out_valid=1.
REQ-019 On a grant to index w, rr_ptr becomes (w+1) mod NUM_REQ; rr_ptr is otherwise unchanged.
REQ-020 If free and no requester is eligible, out_valid becomes 0 on the next edge (when out_ready=1) or stays 0.
REQ-021 While out_valid=1 and out_ready=0, the output payload and out_src_id hold stable, and no in_ready is asserted.
REQ-022 Latency from input handshake to out_valid is exactly 1 cycle.
REQ-023 Throughput is one request per cycle with out_ready held high (back-to-back grants; the output is reloaded in the same cycle it is consumed).
REQ-024 Fairness: a continuously eligible requester is granted within NUM_REQ grants.
REQ-025 A change of req_en affects only arbitration from that cycle; an already-registered request is unaffected and still completes.
REQ-026 The output path has no combinational dependence of out_valid or the payload on out_ready.
REQ-027 in_ready depends combinationally only on out_valid, out_ready, in_valid, req_en and rr_ptr.

Reset
REQ-028 While rst=1: out_valid=0, out_src_id=0, rr_ptr=0, and all in_ready=0, regardless of other inputs.
REQ-029 Output payload registers are not required to reset; they are don't-care while out_valid=0.
REQ-030 Reset asserted mid-transfer discards the registered request; the first grant after deassertion uses rr_ptr=0.

Verification
REQ-031 Single request: NUM_REQ=4, in_valid=4'b0100, address=0x1000, out_ready=1 -> in_ready=4'b0100 same cycle; out_valid=1, out_address=0x1000, out_src_id=2 next cycle.
REQ-032 Round robin: all four valid continuously, out_ready=1 -> grant order 0,1,2,3,0 on consecutive cycles, one out_valid per cycle.
REQ-033 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> payload and out_src_id constant; in_ready=0 throughout; the next grant occurs in the cycle out_ready returns to 1.
REQ-034 Enable mask: req_en=4'b1010, all valid -> only requesters 1 and 3 are granted, alternating.
REQ-035 Reset mid-op: rst pulsed while out_valid=1 and rr_ptr=3 -> out_valid=0 immediately; after release with all valid, the first grant goes to requester 0.
REQ-036 Random traffic: a bench checks hold-valid and payload stability on both sides, the one-hot in_ready rule, in-order per-requester delivery, and the fairness bound from REQ-024.
